// File: rtl/branch_predict_unit_if.sv
// branch_predict_unit_if: fetch-lookup and EX-resolve signal bundle for the
// branch predict unit.
//   master modport : pipeline side (drives PCs/operands, receives prediction
//                    and resolution results)
//   slave  modport : predictor side
// Optional macro BPU_STATS_EN adds the stat_branches/stat_mispredicts outputs.
interface branch_predict_unit_if #(
  parameter int XLEN = 32
);
  // fetch lookup
  logic [XLEN-1:0] pc_if;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  // EX resolution
  logic            ex_valid;
  logic [XLEN-1:0] pc_ex;
  logic [2:0]      br_type;
  logic [XLEN-1:0] reg1;
  logic [XLEN-1:0] reg2;
  logic [XLEN-1:0] target_ex;
  logic            pred_taken_ex;
  logic [XLEN-1:0] pred_target_ex;
  logic            br;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
`ifdef BPU_STATS_EN
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;
`endif

  modport master (
    output pc_if, ex_valid, pc_ex, br_type, reg1, reg2, target_ex,
           pred_taken_ex, pred_target_ex,
`ifdef BPU_STATS_EN
    input  stat_branches, stat_mispredicts,
`endif
    input  pred_taken, pred_target, br, mispredict, redirect_pc
  );

  modport slave (
    input  pc_if, ex_valid, pc_ex, br_type, reg1, reg2, target_ex,
           pred_taken_ex, pred_target_ex,
`ifdef BPU_STATS_EN
    output stat_branches, stat_mispredicts,
`endif
    output pred_taken, pred_target, br, mispredict, redirect_pc
  );
endinterface

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB + 2-bit bimodal BHT with EX-stage
// branch resolution.
//   clk  : clock, all state updates on rising edge
//   rst  : synchronous active-high reset (clears valids, counters -> WNT)
//   bus  : branch_predict_unit_if.slave
//          lookup   pc_if -> pred_taken/pred_target (combinational)
//          resolve  ex_* inputs -> br/mispredict/redirect_pc (combinational)
//          table update on the edge after a resolving cycle
// Optional macro BPU_STATS_EN: adds saturating 32-bit branch / mispredict
// counters on bus.stat_branches / bus.stat_mispredicts.
module branch_predict_unit #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_predict_unit_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} cnt_e;

  logic             r_valid [ENTRIES];
  cnt_e             r_cnt   [ENTRIES];
  logic [TAG_W-1:0] r_tag   [ENTRIES];
  logic [XLEN-1:0]  r_tgt   [ENTRIES];

  // ---------------- lookup ----------------
  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic             w_if_hit;

  assign w_if_idx = bus.pc_if[IDX_W+1:2];
  assign w_if_tag = bus.pc_if[XLEN-1:IDX_W+2];
  assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

  assign bus.pred_taken  = w_if_hit && r_cnt[w_if_idx][1];
  assign bus.pred_target = w_if_hit ? r_tgt[w_if_idx] : bus.pc_if + XLEN'(4);

  // ---------------- resolve ----------------
  logic w_resolve, w_cmp, w_br;

  assign w_resolve = bus.ex_valid && (bus.br_type != 3'd0) && (bus.br_type != 3'd7);

  always_comb begin
    w_cmp = 1'b0;
    case (bus.br_type)
      3'd1:    w_cmp = (bus.reg1 == bus.reg2);
      3'd2:    w_cmp = (bus.reg1 != bus.reg2);
      3'd3:    w_cmp = ($signed(bus.reg1) <  $signed(bus.reg2));
      3'd4:    w_cmp = (bus.reg1 <  bus.reg2);
      3'd5:    w_cmp = ($signed(bus.reg1) >= $signed(bus.reg2));
      3'd6:    w_cmp = (bus.reg1 >= bus.reg2);
      default: w_cmp = 1'b0;
    endcase
  end

  assign w_br            = w_resolve && w_cmp;
  assign bus.br          = w_br;
  assign bus.mispredict  = w_resolve && ((w_br != bus.pred_taken_ex) ||
                                         (w_br && (bus.target_ex != bus.pred_target_ex)));
  assign bus.redirect_pc = w_br ? bus.target_ex : bus.pc_ex + XLEN'(4);

  // ---------------- update ----------------
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_hit;
  cnt_e             w_cnt_cur, w_cnt_nxt;

  assign w_ex_idx  = bus.pc_ex[IDX_W+1:2];
  assign w_ex_tag  = bus.pc_ex[XLEN-1:IDX_W+2];
  assign w_ex_hit  = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_cnt_cur = r_cnt[w_ex_idx];

  // Saturating 2-bit counter step for the entry being resolved.
  always_comb begin
    w_cnt_nxt = w_cnt_cur;
    case (w_cnt_cur)
      SNT: w_cnt_nxt = w_br ? WNT : SNT;
      WNT: w_cnt_nxt = w_br ? WT  : SNT;
      WT:  w_cnt_nxt = w_br ? ST  : WNT;
      ST:  w_cnt_nxt = w_br ? ST  : WT;
      default: w_cnt_nxt = WNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= WNT;
      end
    end else if (w_resolve) begin
      if (w_ex_hit) begin
        r_cnt[w_ex_idx] <= w_cnt_nxt;
      end else if (w_br) begin
        // miss + taken: allocate, evicting any other tag at this index
        r_valid[w_ex_idx] <= 1'b1;
        r_cnt[w_ex_idx]   <= WT;
      end
    end
  end

  // Tag/target carry no reset; they are qualified by r_valid.
  always_ff @(posedge clk) begin
    if (!rst && w_resolve && w_br) begin
      r_tag[w_ex_idx] <= w_ex_tag;
      r_tgt[w_ex_idx] <= bus.target_ex;
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] r_stat_br, r_stat_mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_br  <= '0;
      r_stat_mis <= '0;
    end else begin
      if (w_resolve && !(&r_stat_br))        r_stat_br  <= r_stat_br + 32'd1;
      if (bus.mispredict && !(&r_stat_mis))  r_stat_mis <= r_stat_mis + 32'd1;
    end
  end

  assign bus.stat_branches    = r_stat_br;
  assign bus.stat_mispredicts = r_stat_mis;
`endif

  // PC byte-offset bits never index the table.
  logic w_unused_ok;
  assign w_unused_ok = ^{bus.pc_if[1:0], bus.pc_ex[1:0]};
endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: data and PC width.
REQ-002 SHALL have parameter ENTRIES, default 64: number of BTB/BHT entries; must be a power of two, minimum 4; IDX_W = log2(ENTRIES); TAG_W = XLEN-IDX_W-2.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 pc_if  input  XLEN  fetch PC for lookup.
REQ-006 pred_taken  output  1  prediction for pc_if.
REQ-007 pred_target  output  XLEN  predicted target for pc_if.
REQ-008 ex_valid  input  1  EX stage holds a valid instruction.
REQ-009 pc_ex  input  XLEN  PC of the EX instruction.
REQ-010 br_type  input  3  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BLTU, 5 BGE, 6 BGEU, 7 reserved.
REQ-011 reg1, reg2  input  XLEN  compare operands.
REQ-012 target_ex  input  XLEN  computed branch target.
REQ-013 pred_taken_ex, pred_target_ex  input  1, XLEN  prediction carried down the pipeline with the EX instruction.
REQ-014 br  output  1  resolved taken.
REQ-015 mispredict  output  1  flush request.
REQ-016 redirect_pc  output  XLEN  correct next PC.

Function
REQ-017 SHALL compute br combinationally: EQ/NE/signed LT/unsigned LT/signed GE/unsigned GE at full XLEN width; br=0 for br_type 0 or 7 or when ex_valid=0.
REQ-018 SHALL index the table with pc[IDX_W+1:2] and tag with pc[XLEN-1:IDX_W+2]; each entry holds valid, tag, target, and a 2-bit counter.
REQ-019 SHALL drive pred_taken=1 only when the entry is valid, the tag matches, and counter[1]=1; pred_target = entry target on hit, otherwise pc_if+4.
REQ-020 Lookup SHALL be combinational from registered state, with zero-cycle latency.
REQ-021 SHALL assert mispredict when ex_valid, br_type is in 1..6, and either br!=pred_taken_ex or (br=1 and target_ex!=pred_target_ex).
REQ-022 SHALL drive redirect_pc = target_ex when br=1, else pc_ex+4 (mod 2^XLEN).
REQ-023 Counter FSM: SNT(00), WNT(01), WT(10), ST(11); taken increments, not-taken decrements, saturating at ST and SNT.
REQ-024 The update SHALL occur at the edge following a resolving cycle (ex_valid=1, br_type 1..6) and SHALL NOT occur on any other cycle.
REQ-025 Update on a tag hit: step the counter; on br=1, write target_ex.
REQ-026 Update on a miss with br=1: allocate the entry (replace any occupant), valid=1, tag, target_ex, counter=WT.
REQ-027 Update on a miss with br=0: no table write.
REQ-028 Same-cycle lookup and update of the same index: the lookup SHALL return pre-update contents (no bypass).
REQ-029 pc_if+4 and pc_ex+4 SHALL wrap modulo 2^XLEN.

Reset
REQ-030 While rst=1, all valid bits SHALL clear, all counters SHALL go to WNT, and any table update presented in that cycle SHALL be discarded.
REQ-031 After reset, pred_taken=0 and pred_target=pc_if+4 for every pc_if; br, mispredict, and redirect_pc remain combinational functions of the inputs.
REQ-032 Reset asserted mid-operation SHALL take priority over a simultaneous update.

Configuration
REQ-033 Macro BPU_STATS_EN defined: adds outputs stat_branches and stat_mispredicts (32 bits each), which increment on each resolving cycle and each mispredict respectively, saturate at 2^32-1, and clear on rst.
REQ-034 Macro BPU_STATS_EN undefined: those ports and counters SHALL be absent; all other behaviour is identical.

Verification
REQ-035 After reset, a BEQ at pc_ex=0x100 with reg1=reg2=5, target 0x80 and pred_taken_ex=0 -> br=1, mispredict=1, redirect_pc=0x80; the next cycle, pc_if=0x100 gives pred_taken=1 and pred_target=0x80.
REQ-036 BLT with reg1=0xFFFFFFFF, reg2=1 -> br=1; BLTU with the same operands -> br=0; BGEU with the same operands -> br=1.
REQ-037 An entry in WT followed by three not-taken resolutions -> counter sequence WNT, SNT, SNT; pred_taken=0 after the first.
REQ-038 pc_if=0x100 and an EX update to 0x100 in the same cycle -> the lookup shows old data; the next cycle shows the new data.
REQ-039 pc_ex=0x100 then pc_ex=0x100+4*ENTRIES (same index, different tag), both taken -> the second replaces the first; a lookup of 0x100 then misses.
REQ-040 rst asserted in the same cycle as a taken resolution -> the table stays empty and, with BPU_STATS_EN, both stat counters read 0.
